// File: rtl/wb_bridge_pkg.sv
// wb_bridge_pkg: shared state codes, response constants and sizing helper
// for the N-way Wishbone bridge.
package wb_bridge_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_REQ  = 2'd1;
    localparam state_t ST_RESP = 2'd2;
    localparam state_t ST_ERR  = 2'd3;

    localparam logic [31:0] UNMAPPED_DATA = 32'hFFFF_FFFF;
    localparam logic [31:0] TIMEOUT_DATA  = 32'hDEAD_BEEF;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_bridge_nway_if.sv
// wb_bridge_nway_if: upstream slave bus plus the fanned-out downstream
// master buses of the N-way bridge.
interface wb_bridge_nway_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 11
);
    logic                      wbs_stb_i;
    logic                      wbs_cyc_i;
    logic                      wbs_we_i;
    logic [3:0]                wbs_sel_i;
    logic [31:0]               wbs_dat_i;
    logic [31:0]               wbs_adr_i;
    logic                      wbs_ack_o;
    logic [31:0]               wbs_dat_o;

    logic [NUM_PORTS-1:0]      wbm_stb_o;
    logic [NUM_PORTS-1:0]      wbm_cyc_o;
    logic                      wbm_we_o;
    logic [3:0]                wbm_sel_o;
    logic [31:0]               wbm_dat_o;
    logic [ADDR_WIDTH-1:0]     wbm_adr_o;
    logic [NUM_PORTS-1:0]      wbm_ack_i;
    logic [32*NUM_PORTS-1:0]   wbm_dat_i;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i,
        input  wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o,
        output wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_sel_o,
        output wbm_dat_o, wbm_adr_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i,
        output wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o,
        input  wbm_stb_o, wbm_cyc_o, wbm_we_o, wbm_sel_o,
        input  wbm_dat_o, wbm_adr_o,
        output wbm_ack_i, wbm_dat_i
    );

endinterface

// File: rtl/wb_bridge_watchdog.sv
// wb_bridge_watchdog: 16-bit stall counter; expire flags the cycle in which
// the LIMIT-th consecutive un-acked request cycle occurs.
module wb_bridge_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 16'd1;
        end
    end

    assign expire = enable && (count == LAST);

endmodule

// File: rtl/wb_bridge_nway.sv
// wb_bridge_nway: Wishbone classic 1-to-N bridge with registered request path.
// Optional hung-transfer watchdog enabled by defining WB_BRIDGE_TIMEOUT_EN.
module wb_bridge_nway
    import wb_bridge_pkg::*;
#(
    parameter int          NUM_PORTS      = 4,
    parameter int          ADDR_WIDTH     = 11,
    parameter int          PORT_SEL_LSB   = 16,
    parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    wb_bridge_nway_if.slave  bus,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int IDX_W  = clog2(NUM_PORTS);
    localparam int HI_LSB = PORT_SEL_LSB + IDX_W;

    state_t                state, state_n;
    logic [IDX_W-1:0]      idx_q;
    logic                  we_q;
    logic [3:0]            sel_q;
    logic [31:0]           dat_q;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic [31:0]           rdata_q;

    logic [IDX_W-1:0]      dec_idx;
    logic                  mapped;
    logic                  req;
    logic                  ack_sel;
    logic                  enter_req;
    logic                  expire;
    logic                  to_q;
    logic [NUM_PORTS-1:0]  port_oh;

    assign dec_idx = bus.wbs_adr_i[PORT_SEL_LSB +: IDX_W];
    assign mapped  = (bus.wbs_adr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB])
                  && (int'(dec_idx) < NUM_PORTS);
    assign req     = bus.wbs_stb_i && bus.wbs_cyc_i;
    assign ack_sel = bus.wbm_ack_i[idx_q];
    assign enter_req = (state == ST_IDLE) && req && mapped;
    assign port_oh = NUM_PORTS'(1) << idx_q;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (req) state_n = mapped ? ST_REQ : ST_ERR;
            ST_REQ: begin
                // Abort beats a same-cycle ack; ack beats watchdog expiry.
                if (!bus.wbs_cyc_i) state_n = ST_IDLE;
                else if (ack_sel)   state_n = ST_RESP;
                else if (expire)    state_n = ST_ERR;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= ST_IDLE;
            idx_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            adr_q   <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (state == ST_IDLE && req) begin
                idx_q <= dec_idx;
                we_q  <= bus.wbs_we_i;
                sel_q <= bus.wbs_sel_i;
                dat_q <= bus.wbs_dat_i;
                adr_q <= bus.wbs_adr_i[ADDR_WIDTH-1:0];
            end
            if (state == ST_REQ && ack_sel) begin
                rdata_q <= bus.wbm_dat_i[{idx_q, 5'd0} +: 32];
            end
        end
    end

`ifdef WB_BRIDGE_TIMEOUT_EN
    wb_bridge_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (wb_clk_i),
        .rst    (wb_rst_i),
        .clear  (enter_req),
        .enable ((state == ST_REQ) && bus.wbs_cyc_i && !ack_sel),
        .expire (expire)
    );

    logic fire;
    assign fire = (state == ST_REQ) && bus.wbs_cyc_i && !ack_sel && expire;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            to_q      <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= fire;
            if (enter_req) to_q <= 1'b0;
            else if (state == ST_IDLE && req) to_q <= 1'b0;
            else if (fire) to_q <= 1'b1;
        end
    end
`else
    assign expire    = 1'b0;
    assign to_q      = 1'b0;
    assign timeout_o = 1'b0;
    logic unused_enter_req;
    assign unused_enter_req = enter_req;
`endif

    assign bus.wbm_stb_o = (state == ST_REQ) ? port_oh : '0;
    assign bus.wbm_cyc_o = (state == ST_REQ) ? port_oh : '0;
    assign bus.wbm_we_o  = we_q;
    assign bus.wbm_sel_o = sel_q;
    assign bus.wbm_dat_o = dat_q;
    assign bus.wbm_adr_o = adr_q;

    assign bus.wbs_ack_o = (state == ST_RESP) || (state == ST_ERR);
    assign busy_o        = (state != ST_IDLE);

    always_comb begin
        bus.wbs_dat_o = '0;
        unique case (1'b1)
            (state == ST_RESP): bus.wbs_dat_o = rdata_q;
            (state == ST_ERR):  bus.wbs_dat_o = to_q ? TIMEOUT_DATA
                                                     : UNMAPPED_DATA;
            default: ;
        endcase
    end

endmodule

// File: doc/wb_bridge_nway.md
# wb_bridge_nway

Parametrised N-way Wishbone classic bridge: one upstream slave port (Caravel management SoC) fanned out to NUM_PORTS downstream master ports selected by an address field. It is the generalised successor of the 2-way bridge in the user project wrapper: arbitrary port count, registered request path, single-cycle error response for unmapped addresses, and an optional watchdog that terminates hung transfers. It sits between the wrapper's wishbone pins and the user projects, OpenRAM wrapper and CSR blocks.

## Interface
Parameters:
- NUM_PORTS, 4, number of downstream ports (2..16)
- ADDR_WIDTH, 11, address bits forwarded to each downstream port
- PORT_SEL_LSB, 16, lowest address bit of the port-select field; ADDR_WIDTH <= PORT_SEL_LSB
- BASE_ADDR, 32'h3000_0000, upstream window base; bits above the select field must match
- TIMEOUT_CYCLES, 255, watchdog limit in clocks (1..65535)

Ports:
- wb_clk_i  in  1  clock, all logic on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  upstream strobe, cycle, write enable
- wbs_sel_i  in  4  byte selects
- wbs_dat_i, wbs_adr_i  in  32  write data, byte address
- wbs_ack_o  out  1  upstream acknowledge
- wbs_dat_o  out  32  read data
- wbm_stb_o, wbm_cyc_o  out  NUM_PORTS  per-port strobe/cycle, one-hot or zero
- wbm_we_o  out  1, wbm_sel_o  out  4, wbm_dat_o  out  32, wbm_adr_o  out  ADDR_WIDTH  shared registered request
- wbm_ack_i  in  NUM_PORTS  per-port acknowledge
- wbm_dat_i  in  32*NUM_PORTS  per-port read data, port k at [32k+31:32k]
- busy_o  out  1  high in any state other than IDLE
- timeout_o  out  1  one-cycle pulse on watchdog expiry

## Operation
- IDX_W = clog2(NUM_PORTS). Decode: idx = wbs_adr_i[PORT_SEL_LSB +: IDX_W]; mapped when wbs_adr_i[31:PORT_SEL_LSB+IDX_W] equals same slice of BASE_ADDR and idx < NUM_PORTS.
- FSM states IDLE, REQ, RESP, ERR.
- IDLE: on stb&cyc, register we/sel/dat/adr[ADDR_WIDTH-1:0] and idx; mapped -> REQ, else -> ERR.
- REQ: wbm_stb_o[idx]=wbm_cyc_o[idx]=1, shared outputs hold registered values. wbm_ack_i[idx] -> latch wbm_dat_i slice (reads and writes) -> RESP. Acks on other ports ignored.
- RESP: wbs_ack_o=1 for exactly one cycle, wbs_dat_o = latched data -> IDLE.
- ERR: wbs_ack_o=1 one cycle, wbs_dat_o=32'hFFFF_FFFF, no downstream activity, writes dropped -> IDLE.
- Upstream abort: cyc low while in REQ -> drop downstream stb/cyc next cycle, -> IDLE, no ack.
- wbs_dat_o and wbs_ack_o are zero outside RESP/ERR.

## Timing
- Reset: all outputs 0, state IDLE, watchdog count 0; reset mid-transfer abandons it without ack.
- Request seen at edge N -> downstream stb/cyc asserted from N+1.
- Downstream ack sampled at edge M -> wbs_ack_o high during cycle M+1. Minimum mapped latency: ack_o 2 cycles after request with a zero-wait slave.
- Unmapped: wbs_ack_o high in cycle N+1.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP/ERR (one idle bubble minimum).

## Configuration
- WB_BRIDGE_TIMEOUT_EN defined: 16-bit counter clears on entering REQ, increments each REQ cycle without ack; reaching TIMEOUT_CYCLES -> drop downstream stb/cyc, pulse timeout_o, go to ERR (response data 32'hDEAD_BEEF instead of all-ones for this case). Ack arriving on the same cycle as expiry wins (normal RESP, no timeout_o).
- Not defined: no counter, REQ waits indefinitely; timeout_o tied 0.

## Structure
- Package wb_bridge_pkg: state enum, UNMAPPED_DATA = 32'hFFFF_FFFF, TIMEOUT_DATA = 32'hDEAD_BEEF, clog2 helper.
- Sub-module wb_bridge_watchdog (counter, clear/enable/expire), instantiated only under WB_BRIDGE_TIMEOUT_EN.

## Test plan
- Reset asserted mid-REQ on port 2 -> all outputs 0 asynchronously, next request behaves normally.
- Read 0x3002_0010, port 2 returns 32'h1234_5678 with zero wait -> wbm_adr_o=11'h010, wbs_dat_o=32'h1234_5678, ack 2 cycles after stb.
- Write 0x3001_0004 data 32'hA5A5_A5A5 sel 4'b0011, port 1 acks after 3 wait cycles -> only wbm_stb_o[1] high, ack_o exactly one cycle.
- Read 0x4000_0000 and, with NUM_PORTS=3, 0x3003_0000 -> ack next cycle, data 32'hFFFF_FFFF, no wbm_stb_o.
- With WB_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8, port 0 never acks -> timeout_o pulse, ack_o with 32'hDEAD_BEEF; ack on expiry cycle -> normal response.
- Upstream drops cyc 2 cycles into a port-3 transfer -> wbm_cyc_o[3] low next cycle, no ack_o, busy_o low.
